// File: rtl/word_serializer.sv
// word_serializer: parallel-to-serial converter with a one-word hold buffer.
// Words are shifted out MSB first, one bit per clock, framed by sof/eof.
// An optional run of GAP idle cycles separates consecutive serial words.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - asynchronous active-high reset
//   data_in    - parallel word to serialize (WIDTH bits)
//   data_valid - data_in holds a word
//   data_ready - a word is accepted this cycle when data_valid is also high
//   out        - serial bit, MSB first
//   out_valid  - out carries a word bit this cycle
//   sof        - out is the MSB of a word
//   eof        - out is the LSB of a word
//   busy       - shifter, gap counter or hold buffer occupied
module word_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             out,
    output logic             out_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned GW = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT   = 2'd1,
        S_GAPWAIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_bitcnt;
    logic [GW-1:0]    r_gapcnt;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;

    logic             r_out;
    logic             r_out_valid;
    logic             r_sof;
    logic             r_eof;

    logic             w_accept;
    logic             w_lsb;
    logic             w_gap_done;
    logic             w_load_slot;
    logic             w_load_hold;
    logic             w_load_new;
    logic             w_load;
    logic             w_shift_en;
    logic [WIDTH-1:0] w_load_word;

    logic             w_out_nxt;
    logic             w_valid_nxt;
    logic             w_sof_nxt;
    logic             w_eof_nxt;

    // Handshake: ready depends only on the hold buffer and reset, never on data_valid.
    assign data_ready = !r_hold_full && !rst;
    assign w_accept   = data_valid && data_ready;

    // r_bitcnt holds the number of bits still to come after the one on out.
    assign w_lsb      = (r_state == S_SHIFT) && (r_bitcnt == CW'(0));
    assign w_gap_done = (r_state == S_GAPWAIT) && (r_gapcnt == GW'(1));
    assign w_shift_en = (r_state == S_SHIFT) && !w_lsb;

    // Edges where the shifter may take a new word; hold buffer has priority.
    assign w_load_slot = (r_state == S_IDLE) || (w_lsb && (GAP == 0)) || w_gap_done;
    assign w_load_hold = w_load_slot && r_hold_full;
    assign w_load_new  = w_load_slot && !r_hold_full && w_accept;
    assign w_load      = w_load_hold || w_load_new;
    assign w_load_word = r_hold_full ? r_hold : data_in;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_lsb) begin
                    if (GAP != 0)   w_state_nxt = S_GAPWAIT;
                    else if (w_load) w_state_nxt = S_SHIFT;
                    else             w_state_nxt = S_IDLE;
                end
            end
            S_GAPWAIT: begin
                if (w_gap_done) begin
                    if (w_load) w_state_nxt = S_SHIFT;
                    else        w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: values the serial outputs take after the coming edge.
    always_comb begin
        w_out_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        w_sof_nxt   = 1'b0;
        w_eof_nxt   = 1'b0;
        if (w_load) begin
            w_out_nxt   = w_load_word[WIDTH-1];
            w_valid_nxt = 1'b1;
            w_sof_nxt   = 1'b1;
        end else if (w_shift_en) begin
            w_out_nxt   = r_shift[WIDTH-1];
            w_valid_nxt = 1'b1;
            w_eof_nxt   = (r_bitcnt == CW'(1));
        end
    end

    // Registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
        end else begin
            r_out       <= w_out_nxt;
            r_out_valid <= w_valid_nxt;
            r_sof       <= w_sof_nxt;
            r_eof       <= w_eof_nxt;
        end
    end

    // Shifter keeps the bits not yet presented, left-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
        end else if (w_load) begin
            r_shift  <= {w_load_word[WIDTH-2:0], 1'b0};
            r_bitcnt <= CW'(WIDTH - 1);
        end else if (w_shift_en) begin
            r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
            r_bitcnt <= r_bitcnt - CW'(1);
        end
    end

    // Gap counter: number of idle cycles left, including the current one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gapcnt <= '0;
        end else if (w_lsb && (GAP != 0)) begin
            r_gapcnt <= GW'(GAP);
        end else if ((r_state == S_GAPWAIT) && (r_gapcnt != GW'(0))) begin
            r_gapcnt <= r_gapcnt - GW'(1);
        end
    end

    // Hold buffer: a word arriving while the shifter is occupied waits here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_load_hold) begin
            r_hold_full <= w_accept;
            if (w_accept) r_hold <= data_in;
        end else if (w_accept && !w_load_new) begin
            r_hold      <= data_in;
            r_hold_full <= 1'b1;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign sof       = r_sof;
    assign eof       = r_eof;
    assign busy      = (r_state != S_IDLE) || r_hold_full;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: three instances with different
// WIDTH/GAP settings run the same word lists; a queue-level reference model
// predicts every output each cycle, and a word scoreboard checks that the
// serial words come out complete and in acceptance order.
module tb_word_serializer;

    localparam int NI = 3;

    logic        clk;
    logic        rst;
    logic [2:0]  dv;
    logic [31:0] din [NI];
    logic [2:0]  rdy, so, ov, sf, ef, bz;

    word_serializer #(.WIDTH(8), .GAP(0)) u0 (
        .clk(clk), .rst(rst), .data_in(din[0][7:0]), .data_valid(dv[0]),
        .data_ready(rdy[0]), .out(so[0]), .out_valid(ov[0]), .sof(sf[0]),
        .eof(ef[0]), .busy(bz[0]));

    word_serializer #(.WIDTH(8), .GAP(2)) u1 (
        .clk(clk), .rst(rst), .data_in(din[1][7:0]), .data_valid(dv[1]),
        .data_ready(rdy[1]), .out(so[1]), .out_valid(ov[1]), .sof(sf[1]),
        .eof(ef[1]), .busy(bz[1]));

    word_serializer #(.WIDTH(2), .GAP(1)) u2 (
        .clk(clk), .rst(rst), .data_in(din[2][1:0]), .data_valid(dv[2]),
        .data_ready(rdy[2]), .out(so[2]), .out_valid(ov[2]), .sof(sf[2]),
        .eof(ef[2]), .busy(bz[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: words waiting (at most one, briefly two), the word on
    // the wire with the index of the bit being shown, and idle cycles left.
    int          m_pos [NI];
    logic [31:0] m_cur [NI];
    int          m_gap [NI];
    logic [31:0] m_wq  [NI][2];
    int          m_wn  [NI];
    bit          m_acc [NI];

    // Scoreboard of accepted words and assembler of emitted words.
    logic [31:0] sb    [NI][16];
    int          sb_wr [NI];
    int          sb_rd [NI];
    logic [31:0] asm_v [NI];
    int          asm_n [NI];

    // Per-instance transmit lists.
    logic [31:0] tx    [NI][64];
    int          tx_wr [NI];
    int          tx_rd [NI];
    bit          force_dv;

    function automatic int wof(input int i);
        case (i)
            0: return 8;
            1: return 8;
            default: return 2;
        endcase
    endfunction

    function automatic int gof(input int i);
        case (i)
            0: return 0;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_pos[i] = -1;
        m_cur[i] = '0;
        m_gap[i] = 0;
        m_wn[i]  = 0;
        m_acc[i] = 1'b0;
        sb_wr[i] = 0;
        sb_rd[i] = 0;
        asm_v[i] = '0;
        asm_n[i] = 0;
    endtask

    // One rising edge of the reference model, using the inputs present now.
    task automatic model_step(input int i);
        bit          acc;
        bit          slot;
        logic [31:0] mask;
        if (rst) begin
            model_reset(i);
            return;
        end
        mask = (32'h1 << wof(i)) - 32'h1;
        acc  = dv[i] && (m_wn[i] == 0);
        m_acc[i] = acc;
        slot = 1'b0;
        if (m_pos[i] >= 0) begin
            if (m_pos[i] < wof(i) - 1) begin
                m_pos[i]++;
            end else begin
                m_pos[i] = -1;
                if (gof(i) > 0) m_gap[i] = gof(i);
                else            slot = 1'b1;
            end
        end else if (m_gap[i] > 0) begin
            m_gap[i]--;
            slot = (m_gap[i] == 0);
        end else begin
            slot = 1'b1;
        end
        if (acc) begin
            m_wq[i][m_wn[i]] = din[i] & mask;
            m_wn[i]++;
            sb[i][sb_wr[i] % 16] = din[i] & mask;
            sb_wr[i]++;
        end
        if (slot && m_wn[i] > 0) begin
            m_cur[i]   = m_wq[i][0];
            m_wq[i][0] = m_wq[i][1];
            m_wn[i]--;
            m_pos[i]   = 0;
        end
    endtask

    task automatic compare(input int i);
        bit   ev;
        logic eo;
        ev = (m_pos[i] >= 0);
        eo = ev ? m_cur[i][wof(i) - 1 - m_pos[i]] : 1'b0;
        chk($sformatf("u%0d.out_valid", i), 32'(ov[i]), 32'(ev));
        chk($sformatf("u%0d.out", i),       32'(so[i]), 32'(eo));
        chk($sformatf("u%0d.sof", i),       32'(sf[i]), 32'(m_pos[i] == 0));
        chk($sformatf("u%0d.eof", i),       32'(ef[i]), 32'(m_pos[i] == wof(i) - 1));
        chk($sformatf("u%0d.busy", i),      32'(bz[i]), 32'(ev || m_gap[i] > 0 || m_wn[i] > 0));
        chk($sformatf("u%0d.data_ready", i), 32'(rdy[i]), 32'(m_wn[i] == 0 && !rst));
        // Rebuild each serial word from the DUT's pins and match it to the scoreboard.
        if (ov[i]) begin
            if (sf[i]) begin
                asm_v[i] = '0;
                asm_n[i] = 0;
            end
            asm_v[i] = {asm_v[i][30:0], so[i]};
            asm_n[i]++;
            if (ef[i]) begin
                chk($sformatf("u%0d.word_pending", i), 32'(sb_rd[i] != sb_wr[i]), 32'd1);
                chk($sformatf("u%0d.word_len", i), 32'(asm_n[i]), 32'(wof(i)));
                if (sb_rd[i] != sb_wr[i]) begin
                    chk($sformatf("u%0d.word", i), asm_v[i], sb[i][sb_rd[i] % 16]);
                    sb_rd[i]++;
                end
                asm_n[i] = 0;
            end
        end
    endtask

    task automatic push_all(input logic [31:0] w);
        for (int i = 0; i < NI; i++) begin
            tx[i][tx_wr[i] % 64] = w;
            tx_wr[i]++;
        end
    endtask

    // One clock: present inputs, advance the model at the edge, check at the falling edge.
    task automatic cycle();
        for (int i = 0; i < NI; i++) begin
            if (tx_rd[i] != tx_wr[i] && (force_dv || $urandom_range(0, 3) != 0)) begin
                dv[i]  = 1'b1;
                din[i] = tx[i][tx_rd[i] % 64];
            end else begin
                dv[i]  = 1'b0;
                din[i] = $urandom;
            end
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_step(i);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            compare(i);
            if (m_acc[i]) tx_rd[i]++;
        end
    endtask

    function automatic bit all_idle();
        for (int i = 0; i < NI; i++) begin
            if (m_pos[i] >= 0 || m_gap[i] > 0 || m_wn[i] > 0 || tx_rd[i] != tx_wr[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic run_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (!all_idle() && n < bound) begin
            cycle();
            n++;
        end
        // Two extra cycles confirm nothing trails the last word.
        cycle();
        cycle();
        chk({tag, ".drain"}, 32'(all_idle()), 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        dv  = '0;
        for (int i = 0; i < NI; i++) begin
            din[i] = '0;
            tx_wr[i] = 0;
            tx_rd[i] = 0;
            model_reset(i);
        end
        force_dv = 1'b1;
        @(negedge clk);
        chk("reset.out_valid", 32'(ov), 32'd0);
        chk("reset.data_ready", 32'(rdy), 32'd0);
        chk("reset.busy", 32'(bz), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release.data_ready", 32'(rdy), 32'h7);

        // Single word from idle.
        push_all(32'hA5);
        run_idle("a5", 40);

        // Back-to-back words with the hold buffer filling and stalling a third.
        push_all(32'h0F);
        push_all(32'hF0);
        push_all(32'h3C);
        run_idle("stall", 80);

        // Repeated word across the gap.
        push_all(32'h81);
        push_all(32'h81);
        run_idle("gap", 60);

        // Hold-buffer handoff while a further word waits.
        push_all(32'h33);
        push_all(32'h55);
        push_all(32'hAA);
        run_idle("handoff", 80);

        // Asynchronous reset in the middle of a word with a word held.
        push_all(32'hFF);
        push_all(32'h12);
        begin
            int n;
            n = 0;
            while (m_pos[0] != 3 && n < 20) begin
                cycle();
                n++;
            end
            chk("arst.reach_bit4", 32'(m_pos[0]), 32'd3);
        end
        chk("arst.held_before", 32'(m_wn[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out_valid", 32'(ov), 32'd0);
        chk("arst.out",       32'(so), 32'd0);
        chk("arst.sof_eof",   32'({sf, ef}), 32'd0);
        chk("arst.busy",      32'(bz), 32'd0);
        chk("arst.data_ready", 32'(rdy), 32'd0);
        for (int i = 0; i < NI; i++) begin
            model_reset(i);
            tx_rd[i] = tx_wr[i];
        end
        @(negedge clk);
        cycle();
        rst = 1'b0;
        #1;
        chk("arst.release_ready", 32'(rdy), 32'h7);
        push_all(32'h0A);
        run_idle("after_rst", 40);

        // Randomized traffic with random valid gaps and occasional resets.
        force_dv = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 30; k++) push_all($urandom);
            for (int c = 0; c < 400 && !all_idle(); c++) begin
                rst = ($urandom_range(0, 249) == 0);
                cycle();
            end
            rst = 1'b0;
            run_idle($sformatf("rand%0d", r), 400);
        end

        // Randomized traffic with valid always asserted when a word is available.
        force_dv = 1'b1;
        for (int k = 0; k < 40; k++) push_all($urandom);
        run_idle("rand_dense", 800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
